// File: rtl/string_pkg.sv
// Shared definitions for the string serializer: FSM states, NUL byte and
// width helpers derived from the packed string word width.
package string_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_SEND = 2'd2,
    S_TERM = 2'd3
  } state_t;

  localparam logic [7:0] NUL = 8'h00;

  function automatic int bytes_of(input int len);
    return len / 8;
  endfunction

  function automatic int cw_of(input int len);
    return $clog2(len / 8 + 1);
  endfunction

endpackage

// File: rtl/string_serializer.sv
// Streams a right-justified, NUL-padded string word out one byte per
// handshake, first character first, optionally followed by a NUL terminator.
module string_serializer
  import string_pkg::*;
#(
  parameter int LEN  = 32,
  parameter bit TERM = 1'b1,
  localparam int CW  = cw_of(LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [LEN-1:0] load_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [7:0]     tx_data,
  output logic           tx_last,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  char_count
);

  localparam logic [CW-1:0] NB_C  = CW'(bytes_of(LEN));
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] TWO_C = CW'(2);

  state_t          r_state;
  logic [LEN-1:0]  r_sreg;
  logic [CW-1:0]   r_rem;
  logic [CW-1:0]   r_count;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  logic            r_tx_last;
  logic            r_busy;
  logic            r_done;
  logic            r_load_ready;

  logic [LEN-1:0]  w_sh1;
  logic [LEN-1:0]  w_sh2;
  logic [7:0]      w_top;
  logic [7:0]      w_next;
  logic [7:0]      w_next2;
  logic            w_end;
  logic            w_end_nxt;
  logic            w_tx_hs;
  logic            w_ld_hs;

  // Shifted views give the following bytes without out-of-range slices for small LEN.
  assign w_sh1     = r_sreg << 8;
  assign w_sh2     = r_sreg << 16;
  assign w_top     = r_sreg[LEN-1 -: 8];
  assign w_next    = w_sh1[LEN-1 -: 8];
  assign w_next2   = w_sh2[LEN-1 -: 8];
  assign w_end     = (r_rem == ONE_C) || (w_next == NUL);
  assign w_end_nxt = (r_rem == TWO_C) || (w_next2 == NUL);
  assign w_tx_hs   = r_tx_valid && tx_ready;
  assign w_ld_hs   = load_valid && r_load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_rem        <= '0;
      r_count      <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_last    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ld_hs) begin
            r_sreg       <= load_data;
            r_rem        <= NB_C;
            r_count      <= '0;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
            r_state      <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (w_top != NUL) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_top;
            r_tx_last  <= w_end && (TERM == 1'b0);
            r_state    <= S_SEND;
          end else if (r_rem > ONE_C) begin
            r_sreg <= w_sh1;
            r_rem  <= r_rem - ONE_C;
          end else if (TERM) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= NUL;
            r_tx_last  <= 1'b1;
            r_state    <= S_TERM;
          end else begin
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_SEND: begin
          if (w_tx_hs) begin
            r_count <= r_count + ONE_C;
            r_sreg  <= w_sh1;
            if (r_rem > ONE_C) r_rem <= r_rem - ONE_C;
            if (!w_end) begin
              r_tx_data <= w_next;
              r_tx_last <= w_end_nxt && (TERM == 1'b0);
            end else if (TERM) begin
              r_tx_data <= NUL;
              r_tx_last <= 1'b1;
              r_state   <= S_TERM;
            end else begin
              r_tx_valid   <= 1'b0;
              r_tx_data    <= NUL;
              r_tx_last    <= 1'b0;
              r_busy       <= 1'b0;
              r_load_ready <= 1'b1;
              r_done       <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end
        S_TERM: begin
          if (w_tx_hs) begin
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_tx_valid   <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign tx_last    = r_tx_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign char_count = r_count;

endmodule
